// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and widths for the instruction fetch unit and its word buffer.
package instr_fetch_unit_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] word;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_fetch_buffer.sv
// Two-entry FIFO of {pc, word} records; flush wins over push and pop on the same edge.
module fetch_buffer
  import instr_fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic [1:0]   count
);

  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetcher: walks the PC, reads RAM, and buffers words for decode.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter logic [ADDR_W-1:0] END_ADDR = 16'hFFFF
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              Stop,
  input  logic              Branch_Taken,
  input  logic [ADDR_W-1:0] Branch_Target,
  output logic              Ram_Enable,
  output logic              Ram_RW,
  output logic [ADDR_W-1:0] Ram_Address,
  input  logic [DATA_W-1:0] Ram_Out,
  output logic              Instr_Valid,
  input  logic              Instr_Ready,
  output logic [DATA_W-1:0] Instr,
  output logic [ADDR_W-1:0] Instr_PC,
  output logic              Done
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              issue, flush, pop;
  logic [1:0]        count;
  fetch_entry_t      head, push_entry;

  assign Instr_Valid = (count != 2'd0);
  assign pop         = Instr_Valid & Instr_Ready;

  // A full buffer can still accept a word when the head leaves on the same edge.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush   = 1'b0;
    issue   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (Branch_Taken) begin
          flush = 1'b1;
          pc_d  = Branch_Target;
        end else if (Stop) begin
          state_d = ST_IDLE;
        end else if ((count < 2'd2) || pop) begin
          issue = 1'b1;
          pc_d  = pc_q + 16'd1;
          if (pc_q == END_ADDR) state_d = ST_DONE;
        end
      end
      default: begin
        if (Start) begin
          flush   = 1'b1;
          pc_d    = RESET_PC;
          state_d = ST_FETCH;
        end else if (Branch_Taken) begin
          flush = 1'b1;
          pc_d  = Branch_Target;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign push_entry = '{pc: pc_q, word: Ram_Out};

  fetch_buffer u_buf (
    .clk   (Clk),
    .rst_n (Reset_n),
    .push  (issue),
    .pop   (pop),
    .flush (flush),
    .din   (push_entry),
    .dout  (head),
    .count (count)
  );

  assign Ram_Enable  = issue;
  assign Ram_RW      = issue;
  assign Ram_Address = pc_q;
  assign Instr       = head.word;
  assign Instr_PC    = head.pc;
  assign Done        = (state_q == ST_DONE);

endmodule
